keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Parametrised matrix-keypad scanner with per-frame sampling, debounce, press events and multi-key rejection.
//  Drives one-cold columns, samples active-low rows, emits a one-cycle key_valid strobe with a hex code per
//  debounced press. Sits between the PMOD keypad pins and the game/digit-entry logic.
// PARAMETERS
//  N_ROWS          4        row inputs
//  N_COLS          4        column outputs
//  COL_PERIOD_CYC  100000   cycles each column is driven (1 ms @ 100 MHz)
//  SETTLE_CYC      8        cycles from column drive to row sample; must be >= 3 and < COL_PERIOD_CYC
//  DEBOUNCE_SCANS  4        consecutive identical frames required to accept a state change; >= 1
//  CODE_W          4        key code width; must be >= $clog2(N_ROWS*N_COLS)
// PORTS
//  clk        in   1               system clock, 100 MHz
//  rst_n      in   1               asynchronous reset, active-low
//  row_n      in   N_ROWS          keypad rows, active-low, asynchronous to clk
//  clear      in   1               synchronous clear of the latched key, one-cycle pulse
//  col_n      out  N_COLS          keypad columns, one-cold; all ones = none driven
//  key_code   out  CODE_W          code of the last accepted key
//  key_valid  out  1               one-cycle strobe: new debounced press, key_code updated the same cycle
//  key_held   out  1               debounced single key currently pressed
//  key_multi  out  1               last completed frame contained 2 or more pressed keys
// BEHAVIOUR
//  - Reset: col_n all ones, key_code 0, key_valid/key_held/key_multi 0. Scan FSM in IDLE, all counters 0.
//    Debounced state = NONE. Asserting rst_n low mid-scan aborts the frame; the scan restarts at column 0.
//  - row_n goes through a 2-FF synchroniser before any use.
//  - FSM states:
//    IDLE   -> DRIVE after 1 cycle out of reset.
//    DRIVE  col_n[c] = 0 and the other columns 1; cycle counter runs 0..COL_PERIOD_CYC-1.
//           At count SETTLE_CYC-1, ~row_sync is captured into frame bits [c*N_ROWS +: N_ROWS].
//           At count COL_PERIOD_CYC-1: c++ and counter = 0. When c == N_COLS-1: -> EVAL, c = 0.
//    EVAL   one cycle, columns released. Classifies the frame as NONE, SINGLE(k) or MULTI. -> DRIVE.
//  - Frame period = N_COLS*COL_PERIOD_CYC + 1 cycles.
//  - Key index k = c*N_ROWS + r. The code comes from the package keymap for 4x4, else k[CODE_W-1:0].
//    Default 4x4 map (rows r0..r3 by cols c0..c3):
//      r0: 1 2 3 A
//      r1: 4 5 6 B
//      r2: 7 8 9 C
//      r3: 0 F E D
//  - Debounce: a candidate is the EVAL classification. A stability counter increments when the candidate
//    equals the previous frame's candidate, and resets to 1 otherwise. When it reaches DEBOUNCE_SCANS and the
//    candidate differs from the debounced state, the debounced state is updated. The counter saturates.
//  - Update to SINGLE(k), from NONE or from SINGLE(j != k): key_code <= code(k) and key_valid = 1 for 1 cycle,
//    exactly 1 cycle after EVAL. key_held = 1.
//  - Update to NONE: key_held = 0; no strobe.
//  - Update to MULTI: key_held = 0; no strobe; key_code unchanged.
//  - key_multi is updated every EVAL from the raw frame, not debounced.
//  - A held key produces exactly one strobe and never auto-repeats.
//  - clear: key_code <= 0 next cycle. If clear coincides with an accept, clear wins: the strobe is suppressed,
//    key_code = 0, and the debounced state still updates (so no strobe follows later for that press).
//  - Row glitches shorter than one frame never produce a strobe when DEBOUNCE_SCANS >= 2.
// STRUCTURE
//  - keypad_pkg: KEYMAP_4X4 constant, the scan-state encoding (IDLE/DRIVE/EVAL), classify-result encoding.
//  - Sub-module keypad_debounce: takes the candidate and an eval strobe; outputs the debounced state and an
//    accept pulse. The scan FSM, counters and synchroniser stay in keypad_scan_ctrl.
// TESTING  (COL_PERIOD_CYC=16, SETTLE_CYC=4, DEBOUNCE_SCANS=2, 4x4)
//  - Reset: rst_n low -> col_n=4'hF, key_code=0, all flags 0. Release -> col_n=4'b1110 within 2 cycles.
//  - Press r1,c2 held for 3 frames -> exactly one key_valid, key_code=4'h6, key_held=1. Release -> key_held=0,
//    no strobe.
//  - Press r3,c1 for 1 frame only -> no key_valid, key_code unchanged.
//  - Press r0,c0 and r2,c3 together -> key_multi=1, no strobe. Drop r2,c3 -> strobe, key_code=4'h1.
//  - Slide from key 5 to key 9 without an intervening release -> two strobes, key_code 4'h5 then 4'h9.
//  - Clear pulse on the same cycle as the accept for key A -> no strobe, key_code=0. rst_n low mid-frame ->
//    col_n=4'hF immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner: scan-FSM state encoding,
// frame classification encoding and the default 4x4 key map.
// No ports; imported by keypad_scan_ctrl and keypad_debounce.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_EVAL  = 2'd2
  } scan_state_t;

  typedef enum logic [1:0] {
    CLS_NONE   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } cls_t;

  // Indexed by key index k = c*4 + r, so each group of four entries is one
  // column read top to bottom (r0..r3).
  localparam logic [3:0] KEYMAP_4X4 [16] = '{
    4'h1, 4'h4, 4'h7, 4'h0,   // c0
    4'h2, 4'h5, 4'h8, 4'hF,   // c1
    4'h3, 4'h6, 4'h9, 4'hE,   // c2
    4'hA, 4'hB, 4'hC, 4'hD    // c3
  };

  function automatic logic [3:0] keymap_4x4(input logic [3:0] k);
    return KEYMAP_4X4[k];
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-event bundle between the scanner and its neighbours.
// master: scanner side (drives columns and key outputs, takes rows and clear).
// slave : keypad/consumer side (drives rows and clear, observes the rest).
interface keypad_scan_ctrl_if #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int CODE_W = 4
);
  logic [N_ROWS-1:0] row_n;      // active-low rows, asynchronous to clk
  logic              clear;      // one-cycle pulse: zero the latched key code
  logic [N_COLS-1:0] col_n;      // one-cold column drive, all ones = idle
  logic [CODE_W-1:0] key_code;   // code of the last accepted key
  logic              key_valid;  // one-cycle strobe per debounced press
  logic              key_held;   // debounced single key currently down
  logic              key_multi;  // last frame had two or more keys down

  modport master (
    input  row_n, clear,
    output col_n, key_code, key_valid, key_held, key_multi
  );

  modport slave (
    output row_n, clear,
    input  col_n, key_code, key_valid, key_held, key_multi
  );
endinterface

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: accepts a new key state after DEBOUNCE_SCANS identical frames.
// Latency: debounced state updates on the clock edge ending the eval cycle; accept is combinational in that cycle.
// Backpressure: none; one candidate per eval strobe, always consumed.
// Ports: clk, rst_n; eval_stb + cand_cls/cand_idx (frame classification);
//        deb_cls (debounced state), accept (state is about to become a new SINGLE).
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int IDX_W          = 4,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             eval_stb,
  input  cls_t             cand_cls,
  input  logic [IDX_W-1:0] cand_idx,
  output cls_t             deb_cls,
  output logic             accept
);

  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

  cls_t              prev_cls_q;
  logic [IDX_W-1:0]  prev_idx_q;
  logic [STAB_W-1:0] stab_q;
  logic [STAB_W-1:0] stab_nxt;
  cls_t              deb_cls_q;
  logic [IDX_W-1:0]  deb_idx_q;
  logic              same_as_prev;
  logic              differs;
  logic              update;

  // Candidate index is zero for NONE/MULTI, so a full compare of
  // (class, index) is a correct equality test for every class.
  always_comb begin
    same_as_prev = (cand_cls == prev_cls_q) && (cand_idx == prev_idx_q);
    if (!same_as_prev)
      stab_nxt = STAB_W'(1);
    else if (stab_q == STAB_MAX)
      stab_nxt = stab_q;
    else
      stab_nxt = stab_q + STAB_W'(1);
    differs = (cand_cls != deb_cls_q) || (cand_idx != deb_idx_q);
    update  = eval_stb && (stab_nxt == STAB_MAX) && differs;
    accept  = update && (cand_cls == CLS_SINGLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_cls_q <= CLS_NONE;
      prev_idx_q <= '0;
      stab_q     <= '0;
      deb_cls_q  <= CLS_NONE;
      deb_idx_q  <= '0;
    end else if (eval_stb) begin
      prev_cls_q <= cand_cls;
      prev_idx_q <= cand_idx;
      stab_q     <= stab_nxt;
      if (update) begin
        deb_cls_q <= cand_cls;
        deb_idx_q <= cand_idx;
      end
    end
  end

  assign deb_cls = deb_cls_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: one-cold column drive, synchronised row sampling, debounced press events.
// Latency: key_valid/key_code appear 1 cycle after the frame's eval cycle; frame = N_COLS*COL_PERIOD_CYC+1 cycles.
// Backpressure: none; key_valid is a fire-and-forget strobe, the consumer must take it in that cycle.
// Ports: clk, rst_n (async, active-low); kp (master modport): row_n/clear in,
//        col_n/key_code/key_valid/key_held/key_multi out.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int COL_PERIOD_CYC = 100000,
  parameter int SETTLE_CYC     = 8,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int CODE_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  keypad_scan_ctrl_if.master   kp
);

  localparam int N_KEYS = N_ROWS * N_COLS;
  localparam int IDX_W  = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
  localparam int CNT_W  = (COL_PERIOD_CYC > 1) ? $clog2(COL_PERIOD_CYC) : 1;
  localparam int COL_W  = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  scan_state_t       state_q;
  scan_state_t       state_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [COL_W-1:0]  col_q;
  logic              cnt_last;
  logic              col_last;
  logic              sample_now;
  logic              eval_stb;
  logic [N_COLS-1:0] col_drv;

  logic [N_ROWS-1:0] row_meta_q;
  logic [N_ROWS-1:0] row_sync_q;
  logic [N_KEYS-1:0] frame_q;

  logic [1:0]        n_hit;
  logic [IDX_W-1:0]  hit_idx;
  cls_t              cand_cls;
  logic [IDX_W-1:0]  cand_idx;
  cls_t              deb_cls;
  logic              accept;

  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q;
  logic              key_multi_q;

  function automatic logic [CODE_W-1:0] code_of(input logic [IDX_W-1:0] k);
    if (N_ROWS == 4 && N_COLS == 4)
      return CODE_W'(keymap_4x4(4'(k)));
    return CODE_W'(k);
  endfunction

  // Rows are asynchronous; idle level (all ones) is the reset value so no
  // phantom press is seen while the synchroniser fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= kp.row_n;
      row_sync_q <= row_meta_q;
    end
  end

  assign cnt_last   = (cnt_q == CNT_W'(COL_PERIOD_CYC - 1));
  assign col_last   = (col_q == COL_W'(N_COLS - 1));
  assign sample_now = (state_q == ST_DRIVE) && (cnt_q == CNT_W'(SETTLE_CYC - 1));

  // Scan FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // Scan FSM: next state
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  state_nxt = ST_DRIVE;
      ST_DRIVE: if (cnt_last && col_last) state_nxt = ST_EVAL;
      ST_EVAL:  state_nxt = ST_DRIVE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Scan FSM: outputs. Columns are decoded from registered state, and are
  // released in IDLE (including during reset) and EVAL.
  always_comb begin
    col_drv  = '1;
    eval_stb = 1'b0;
    case (state_q)
      ST_DRIVE: begin
        for (int ci = 0; ci < N_COLS; ci++)
          col_drv[ci] = (col_q != COL_W'(ci));
      end
      ST_EVAL:  eval_stb = 1'b1;
      default:  ;
    endcase
  end

  assign kp.col_n = col_drv;

  // Column dwell counter and column index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      col_q <= '0;
    end else if (state_q == ST_DRIVE) begin
      if (cnt_last) begin
        cnt_q <= '0;
        col_q <= col_last ? '0 : col_q + COL_W'(1);
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  // Every column slice is rewritten once per frame, so no frame clear is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
    end else if (sample_now) begin
      for (int ci = 0; ci < N_COLS; ci++)
        if (col_q == COL_W'(ci))
          frame_q[ci*N_ROWS +: N_ROWS] <= ~row_sync_q;
    end
  end

  // Frame classification: count pressed keys (saturating at 2) and remember
  // the index of a pressed key, which is the key itself when exactly one is down.
  always_comb begin
    n_hit   = 2'd0;
    hit_idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (frame_q[i]) begin
        hit_idx = IDX_W'(i);
        if (n_hit != 2'd2) n_hit = n_hit + 2'd1;
      end
    end
    case (n_hit)
      2'd0:    cand_cls = CLS_NONE;
      2'd1:    cand_cls = CLS_SINGLE;
      default: cand_cls = CLS_MULTI;
    endcase
    cand_idx = (n_hit == 2'd1) ? hit_idx : '0;
  end

  keypad_debounce #(
    .IDX_W          (IDX_W),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .eval_stb (eval_stb),
    .cand_cls (cand_cls),
    .cand_idx (cand_idx),
    .deb_cls  (deb_cls),
    .accept   (accept)
  );

  // Clear dominates an accept in the same cycle: the code is zeroed and the
  // strobe dropped, while the debouncer still records the press so it is
  // never reported later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_multi_q <= 1'b0;
    end else begin
      key_valid_q <= accept && !kp.clear;
      if (kp.clear)
        key_code_q <= '0;
      else if (accept)
        key_code_q <= code_of(cand_idx);
      if (eval_stb)
        key_multi_q <= (n_hit == 2'd2);
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (deb_cls == CLS_SINGLE);
  assign kp.key_multi = key_multi_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

  localparam int NR     = 4;
  localparam int NC     = 4;
  localparam int CW     = 4;
  localparam int COLP   = 16;
  localparam int SETTLE = 4;
  localparam int DEB    = 2;
  localparam int FRAME  = NC * COLP + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  keypad_scan_ctrl_if #(.N_ROWS(NR), .N_COLS(NC), .CODE_W(CW)) kif ();

  keypad_scan_ctrl #(
    .N_ROWS(NR), .N_COLS(NC), .COL_PERIOD_CYC(COLP),
    .SETTLE_CYC(SETTLE), .DEBOUNCE_SCANS(DEB), .CODE_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  // Physical keypad: a pressed key at (r,c) pulls row r low while column c is driven.
  logic [15:0]   pressed;
  logic [NR-1:0] row_drv;
  always_comb begin
    row_drv = '1;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (pressed[c*NR + r] && !kif.col_n[c]) row_drv[r] = 1'b0;
  end
  assign kif.row_n = row_drv;

  // Key legend as printed on the keypad, grid[row][col].
  logic [3:0] grid [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model, frame granularity: 0 = none, 1 = single, 2 = multi.
  int         m_prev_cls, m_prev_idx, m_run, m_deb_cls, m_deb_idx;
  logic [3:0] m_code;
  bit         m_valid, m_multi;

  task automatic model_reset();
    m_prev_cls = 0; m_prev_idx = 0; m_run = 0;
    m_deb_cls  = 0; m_deb_idx  = 0;
    m_code = 4'h0; m_valid = 1'b0; m_multi = 1'b0;
  endtask

  task automatic model_eval(input logic [15:0] keys, input bit clr);
    int n, cls, idx;
    n   = $countones(keys);
    cls = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    idx = 0;
    if (cls == 1)
      for (int i = 0; i < 16; i++) if (keys[i]) idx = i;
    if (cls == m_prev_cls && idx == m_prev_idx) begin
      if (m_run < DEB) m_run++;
    end else begin
      m_run = 1;
    end
    m_prev_cls = cls;
    m_prev_idx = idx;
    m_valid    = 1'b0;
    if (m_run >= DEB && (cls != m_deb_cls || idx != m_deb_idx)) begin
      m_deb_cls = cls;
      m_deb_idx = idx;
      if (cls == 1 && !clr) begin
        m_valid = 1'b1;
        m_code  = grid[idx % 4][idx / 4];
      end
    end
    if (clr) m_code = 4'h0;
    m_multi = (n >= 2);
  endtask

  // Entered on the negedge just after an eval cycle: hold `keys` for one whole
  // frame, pulse clear into that frame's eval if asked, then check the outcome.
  task automatic run_frame(input logic [15:0] keys, input bit clr);
    int  strays;
    bit  found;
    pressed = keys;
    strays  = 0;
    found   = 1'b0;
    for (int t = 0; t < FRAME + 10; t++) begin
      @(negedge clk);
      if (kif.col_n == 4'hF) begin
        found = 1'b1;
        break;
      end
      if (kif.key_valid) strays++;
    end
    chk("eval_seen", 32'(found), 32'd1);
    chk("stray_vld", 32'(strays), 32'd0);
    kif.clear = clr;
    model_eval(keys, clr);
    @(negedge clk);
    kif.clear = 1'b0;
    chk("key_valid", 32'(kif.key_valid), 32'(m_valid));
    chk("key_code",  32'(kif.key_code),  32'(m_code));
    chk("key_held",  32'(kif.key_held),  32'(m_deb_cls == 1));
    chk("key_multi", 32'(kif.key_multi), 32'(m_multi));
  endtask

  // Directed frames: {clear_at_eval, key bitmap indexed c*4+r}.
  localparam int N_DIR = 27;
  logic [16:0] dir_tab [N_DIR] = '{
    17'h00000, 17'h00000,
    17'h00200, 17'h00200, 17'h00200,             // r1,c2 ("6") held 3 frames
    17'h00000, 17'h00000, 17'h00000,
    17'h00080,                                    // r3,c1 for one frame only
    17'h00000, 17'h00000,
    17'h04001, 17'h04001,                         // r0,c0 + r2,c3 together
    17'h00001, 17'h00001, 17'h00001,              // drop r2,c3 -> "1"
    17'h00000, 17'h00000,
    17'h00020, 17'h00020, 17'h00020,              // "5"
    17'h00400, 17'h00400, 17'h00400,              // slide to "9"
    17'h00000, 17'h01000, 17'h11000               // "A" with clear on its accept
  };

  initial begin
    logic [15:0] pat;
    int          sel, hold, a, b;

    pressed   = '0;
    kif.clear = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_col_n",  32'(kif.col_n),     32'hF);
    chk("rst_code",   32'(kif.key_code),  32'h0);
    chk("rst_valid",  32'(kif.key_valid), 32'h0);
    chk("rst_held",   32'(kif.key_held),  32'h0);
    chk("rst_multi",  32'(kif.key_multi), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("start_col0", 32'(kif.col_n), 32'hE);

    for (int i = 0; i < N_DIR; i++) run_frame(dir_tab[i][15:0], dir_tab[i][16]);
    run_frame(16'h1000, 1'b0);
    run_frame(16'h0000, 1'b0);
    run_frame(16'h0000, 1'b0);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      pat = '0;
      if (sel >= 4 && sel < 8) begin
        pat[$urandom_range(0, 15)] = 1'b1;
      end else if (sel >= 8) begin
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        pat[a] = 1'b1;
        pat[b] = 1'b1;
      end
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) run_frame(pat, ($urandom_range(0, 9) == 0));
    end

    // Latch a key, then reset in the middle of a frame.
    run_frame(16'h0000, 1'b0);
    run_frame(16'h0200, 1'b0);
    run_frame(16'h0200, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_col_n", 32'(kif.col_n),     32'hF);
    chk("midrst_code",  32'(kif.key_code),  32'h0);
    chk("midrst_held",  32'(kif.key_held),  32'h0);
    chk("midrst_valid", 32'(kif.key_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("restart_col0", 32'(kif.col_n), 32'hE);
    run_frame(16'h0200, 1'b0);
    run_frame(16'h0200, 1'b0);
    run_frame(16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
